// File: rtl/float2int_pkg.sv
// rtl/float2int_pkg.sv - shared constants, FSM state type and reference decode for float2int_dec
//
// Purpose: widths of the 7-bit minifloat and the 11-bit integer it encodes,
// the decoder state encoding, and an arithmetic reference decode used to
// predict results independently of the iterative shifter.
package float2int_pkg;

   localparam int FLT_W = 7;
   localparam int EXP_W = 3;
   localparam int MAN_W = 4;
   localparam int INT_W = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Value a code stands for. With round_mid set and e>=2 the midpoint of the
   // truncated interval (2^(e-2)) is added on top of the floor value.
   function automatic logic [INT_W-1:0] decode_ref(input logic [FLT_W-1:0] code,
                                                   input logic             round_mid);
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] m;
      int unsigned      v;
      e = code[FLT_W-1:MAN_W];
      m = code[MAN_W-1:0];
      if (e == '0) begin
         v = int'(m);
      end else begin
         v = (16 + int'(m)) * (1 << (int'(e) - 1));
         if (round_mid && (e >= 3'd2)) begin
            v = v + (1 << (int'(e) - 2));
         end
      end
      return v[INT_W-1:0];
   endfunction

endpackage

// File: rtl/float2int_dec.sv
// rtl/float2int_dec.sv - iterative minifloat-to-integer decoder with valid/ready handshakes
//
// Purpose: reconstructs the 11-bit unsigned integer for a 7-bit minifloat
// code ([6:4] exponent, [3:0] mantissa) by loading the significand and
// shifting it left one bit per cycle, e-1 times.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   in_valid   float code present
//   in_ready   block can accept a code this cycle
//   in_float   7-bit code, sampled only on accept
//   out_valid  out_int holds a finished result
//   out_ready  sink accepts the result
//   out_int    decoded 11-bit integer, meaningful while out_valid=1
//
// Parameter ROUND_MID: 0 truncates (zero fill), 1 reconstructs the midpoint.
module float2int_dec
   import float2int_pkg::*;
#(
   parameter int ROUND_MID = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FLT_W-1:0]  in_float,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INT_W-1:0]  out_int
);

   localparam logic RMID = (ROUND_MID != 0);

   state_t           state;
   state_t           state_nxt;
   logic [INT_W-1:0] sreg;
   logic [EXP_W-1:0] cnt;
   logic             first;
   logic             accept;
   logic [EXP_W-1:0] exp_in;
   logic [MAN_W-1:0] man_in;

   assign exp_in    = in_float[FLT_W-1:MAN_W];
   assign man_in    = in_float[MAN_W-1:0];
   assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
   assign out_valid = (state == DONE);
   assign out_int   = sreg;
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (cnt == '0) state_nxt = DONE;
         DONE: begin
            // Accept has precedence so a new code in the transfer cycle
            // starts immediately (back-to-back streaming).
            if (accept)         state_nxt = SHIFT;
            else if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg  <= '0;
         cnt   <= '0;
         first <= 1'b0;
      end else if (accept) begin
         // Hidden leading one only for normalised codes (e != 0).
         sreg  <= {{(INT_W-MAN_W-1){1'b0}}, (exp_in != '0), man_in};
         cnt   <= (exp_in == '0) ? '0 : exp_in - 3'd1;
         first <= 1'b1;
      end else if ((state == SHIFT) && (cnt != '0)) begin
         // Midpoint rounding: only the first shift inserts a one, which
         // ends up at weight 2^(e-2) after the remaining shifts.
         sreg  <= {sreg[INT_W-2:0], RMID && first};
         cnt   <= cnt - 3'd1;
         first <= 1'b0;
      end
   end

endmodule

// File: tb/tb_float2int_dec.sv
// tb/tb_float2int_dec.sv - self-checking scoreboard bench for float2int_dec
module tb_float2int_dec;
   import float2int_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  iv;
   logic [1:0]  ir;
   logic [1:0]  ov;
   logic [1:0]  ordy;
   logic [6:0]  fl [2];
   logic [10:0] oi [2];

   int tests = 0;
   int fails = 0;

   logic [10:0] q0 [$];
   logic [10:0] q1 [$];

   always #5 clk = ~clk;

   float2int_dec #(.ROUND_MID(0)) dut0 (
      .clk(clk), .rst(rst),
      .in_valid(iv[0]), .in_ready(ir[0]), .in_float(fl[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .out_int(oi[0])
   );

   float2int_dec #(.ROUND_MID(1)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(iv[1]), .in_ready(ir[1]), .in_float(fl[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .out_int(oi[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: pop/compare on output transfer, push prediction on accept.
   always @(negedge clk) begin
      if (rst) begin
         q0.delete();
         q1.delete();
      end else begin
         if (ov[0] && ordy[0]) begin
            check("sb0_pending", q0.size(), 1);
            if (q0.size() > 0) check("sb0_value", oi[0], q0.pop_front());
         end
         if (ov[1] && ordy[1]) begin
            check("sb1_pending", q1.size(), 1);
            if (q1.size() > 0) check("sb1_value", oi[1], q1.pop_front());
         end
         if (iv[0] && ir[0]) q0.push_back(decode_ref(fl[0], 1'b0));
         if (iv[1] && ir[1]) q1.push_back(decode_ref(fl[1], 1'b1));
      end
   end

   task automatic run1(input int k, input logic [6:0] code, input logic [10:0] exp_val,
                       input int exp_lat);
      int lat;
      @(posedge clk); #1;
      ordy[k] = 1'b1;
      iv[k]   = 1'b1;
      fl[k]   = code;
      @(negedge clk);
      check($sformatf("rdy_%0d_%02h", k, code), ir[k], 1);
      @(posedge clk); #1;
      iv[k] = 1'b0;
      fl[k] = 7'h55;   // must be ignored while shifting
      lat = 0;
      @(negedge clk);
      while (!ov[k] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("lat_%0d_%02h", k, code), lat, exp_lat);
      check($sformatf("val_%0d_%02h", k, code), oi[k], exp_val);
   endtask

   task automatic stream(input int k);
      bit done;
      done = 1'b0;
      @(posedge clk); #1;
      fork
         begin
            for (int c = 0; c < 128; c++) begin
               bit acc;
               int n;
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk); #1;
               end
               iv[k] = 1'b1;
               fl[k] = 7'(c);
               n = 0;
               do begin
                  @(negedge clk);
                  acc = ir[k];
                  @(posedge clk); #1;
                  n++;
               end while (!acc && n < 100);
               if (!acc) check($sformatf("stream_acc_%0d", k), acc, 1);
               iv[k] = 1'b0;
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               ordy[k] = ($urandom_range(0, 3) != 0);
            end
         end
      join
      ordy[k] = 1'b1;
      repeat (15) @(posedge clk);
      @(negedge clk);
      if (k == 0) check("drain0", q0.size(), 0);
      else        check("drain1", q1.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      iv    = '0;
      ordy  = '0;
      fl[0] = '0;
      fl[1] = '0;
      rst   = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_in_ready%0d", k), ir[k], 1);
         check($sformatf("rst_out_valid%0d", k), ov[k], 0);
         check($sformatf("rst_out_int%0d", k), oi[k], 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      run1(0, 7'h00, 11'h000, 1);
      run1(0, 7'h0F, 11'h00F, 1);
      run1(0, 7'h1F, 11'h01F, 1);
      run1(0, 7'h35, 11'h054, 3);
      run1(0, 7'h7F, 11'h7C0, 7);

      run1(1, 7'h7F, 11'h7E0, 7);
      run1(1, 7'h35, 11'h056, 3);
      run1(1, 7'h1F, 11'h01F, 1);

      // Backpressure with a pending code during the stall.
      @(posedge clk); #1;
      ordy[0] = 1'b0;
      iv[0]   = 1'b1;
      fl[0]   = 7'h35;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      n = 0;
      @(negedge clk);
      while (!ov[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", ov[0], 1);
         check("bp_out_int", oi[0], 11'h054);
         check("bp_in_ready", ir[0], 0);
         @(posedge clk); #1;
         if (i == 0) begin
            iv[0] = 1'b1;
            fl[0] = 7'h20;
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      ordy[0] = 1'b1;
      @(negedge clk);
      check("bp_release_in_ready", ir[0], 1);
      @(posedge clk); #1;
      iv[0] = 1'b0;
      n = 0;
      @(negedge clk);
      while (!ov[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("bp_next_lat", n, 2);
      check("bp_next_val", oi[0], 11'h020);

      // Reset during a long conversion.
      @(posedge clk); #1;
      iv[0] = 1'b1;
      fl[0] = 7'h7F;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_in_ready", ir[0], 1);
      check("rstmid_out_valid", ov[0], 0);
      check("rstmid_out_int", oi[0], 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("rstmid_no_output", ov[0], 0);
      end

      stream(0);
      stream(1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
